seg_signed_dec: RTL and testbench

Sequential signed-binary to multi-digit seven-segment decimal driver. Accepts a W-bit two's-complement value through a valid/ready handshake and converts its magnitude to BCD with a bit-serial shift-add-3 (double-dabble) engine. It drives ND active-low seven-segment digits with a minus sign and holds the result until the next accepted value. It sits between the datapath (ALU or counter result) and the board's seven-segment pins, replacing the fixed 4-bit single-digit decoder.

---
 rtl/seg_pkg.sv | 56 +++++
 rtl/seg_signed_dec_if.sv | 27 ++
 rtl/seg_bcd_digit.sv | 14 +
 rtl/seg_signed_dec.sv | 119 +++++++++++
 tb/tb_seg_signed_dec.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared segment codes, the BCD-to-segment map and the conversion FSM state type
// for the signed seven-segment decimal driver.
package seg_pkg;

  // Active-low a..g,dp; dp is always off.
  localparam logic [7:0] SEG_0     = 8'h03;
  localparam logic [7:0] SEG_1     = 8'h9F;
  localparam logic [7:0] SEG_2     = 8'h25;
  localparam logic [7:0] SEG_3     = 8'h0D;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h49;
  localparam logic [7:0] SEG_6     = 8'h41;
  localparam logic [7:0] SEG_7     = 8'h1F;
  localparam logic [7:0] SEG_8     = 8'h01;
  localparam logic [7:0] SEG_9     = 8'h09;
  localparam logic [7:0] SEG_MINUS = 8'hFD;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    FMT  = 2'd2
  } state_t;

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Decimal digit count of 2^(w-1), the largest magnitude a w-bit signed value can carry.
  function automatic int dec_digits(input int w);
    longint v;
    int     n;
    v = longint'(1) << (w - 1);
    n = 0;
    while (v > 0) begin
      v = v / 10;
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/seg_signed_dec_if.sv
// Value handshake plus display output bundle of the signed seven-segment driver.
interface seg_signed_dec_if #(
  parameter int W  = 8,
  parameter int ND = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic            done;
  logic [8*ND-1:0] o_seg;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  done,
    input  o_seg
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output done,
    output o_seg
  );
endinterface

// File: rtl/seg_bcd_digit.sv
// One double-dabble BCD nibble: add 3 when >= 5, then shift left taking cin as LSB;
// the bit shifted out feeds the next nibble up.
module seg_bcd_digit (
  input  logic [3:0] din,
  input  logic       cin,
  output logic [3:0] dout,
  output logic       cout
);
  logic [3:0] adj;

  assign adj  = (din >= 4'd5) ? din + 4'd3 : din;
  assign dout = {adj[2:0], cin};
  assign cout = adj[3];
endmodule

// File: rtl/seg_signed_dec.sv
// Signed W-bit to ND-digit active-low seven-segment driver (bit-serial double-dabble).
// Define SEG_LZB_EN for leading-zero blanking with a floating minus sign.
module seg_signed_dec
  import seg_pkg::*;
#(
  parameter int W  = 8,
  parameter int ND = 4
) (
  input logic             clk,
  input logic             rst_n,
  seg_signed_dec_if.slave bus
);
  localparam int NB = ND - 1;
  localparam int CW = $clog2(W + 1);

  if (W < 2 || NB < dec_digits(W)) begin : g_cfg_err
    $error("seg_signed_dec: W=%0d needs more than ND-1=%0d numeric digits", W, NB);
  end

  state_t              state;
  logic                sign;
  logic [W-1:0]        mag;
  logic [4*NB-1:0]     bcd;
  logic [4*NB-1:0]     bcd_nxt;
  logic [NB:0]         cy;
  logic [CW-1:0]       cnt;
  logic                ready_q;
  logic                done_q;
  logic [ND-1:0][7:0]  seg_q;
  logic [ND-1:0][7:0]  seg_nxt;
  logic                carry_unused;

  // Magnitude MSB enters the lowest nibble; the chain ripples up through all nibbles.
  assign cy[0] = mag[W-1];

  for (genvar i = 0; i < NB; i++) begin : g_dig
    seg_bcd_digit u_dig (
      .din  (bcd[4*i +: 4]),
      .cin  (cy[i]),
      .dout (bcd_nxt[4*i +: 4]),
      .cout (cy[i+1])
    );
  end

  // The digit-count check guarantees nothing ever leaves the top nibble.
  assign carry_unused = cy[NB];

`ifdef SEG_LZB_EN
  int hi;

  always_comb begin
    seg_nxt = {ND{SEG_BLANK}};
    hi      = 0;
    for (int i = 0; i < NB; i++)
      if (bcd[4*i +: 4] != 4'd0) hi = i;
    // Digits at or below the highest non-zero one are shown; digit 0 always is.
    for (int i = 0; i < NB; i++)
      if (i <= hi) seg_nxt[i] = bcd_to_seg(bcd[4*i +: 4]);
    for (int i = 0; i < ND; i++)
      if (sign && i == hi + 1) seg_nxt[i] = SEG_MINUS;
  end
`else
  always_comb begin
    seg_nxt = {ND{SEG_BLANK}};
    for (int i = 0; i < NB; i++)
      seg_nxt[i] = bcd_to_seg(bcd[4*i +: 4]);
    if (sign) seg_nxt[NB] = SEG_MINUS;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      seg_q   <= {ND{SEG_BLANK}};
      sign    <= 1'b0;
      mag     <= '0;
      bcd     <= '0;
      cnt     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sign    <= bus.in_data[W-1];
            // -2^(W-1) negates to itself, which is exactly its unsigned magnitude.
            mag     <= bus.in_data[W-1] ? W'(~bus.in_data + 1'b1) : bus.in_data;
            bcd     <= '0;
            cnt     <= '0;
            ready_q <= 1'b0;
            state   <= CONV;
          end
        end
        CONV: begin
          bcd <= bcd_nxt;
          mag <= {mag[W-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) state <= FMT;
        end
        FMT: begin
          seg_q   <= seg_nxt;
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready = ready_q;
  assign bus.done     = done_q;
  assign bus.o_seg    = seg_q;

endmodule

// File: tb/tb_seg_signed_dec.sv
// Directed bench for seg_signed_dec (W=8, ND=4); expectations follow SEG_LZB_EN.
module tb_seg_signed_dec;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  seg_signed_dec_if #(.W(8), .ND(4)) bus ();

  seg_signed_dec #(.W(8), .ND(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] E_N128 = 32'hFD9F2501;
  localparam logic [31:0] E_127  = 32'hFF9F251F;
  localparam logic [31:0] E_N100 = 32'hFD9F0303;
`ifdef SEG_LZB_EN
  localparam logic [31:0] E_P7   = 32'hFFFFFF1F;
  localparam logic [31:0] E_N7   = 32'hFFFFFD1F;
  localparam logic [31:0] E_Z    = 32'hFFFFFF03;
  localparam logic [31:0] E_5    = 32'hFFFFFF49;
  localparam logic [31:0] E_20   = 32'hFFFF2503;
  localparam logic [31:0] E_30   = 32'hFFFF0D03;
  localparam logic [31:0] E_N1   = 32'hFFFFFD9F;
`else
  localparam logic [31:0] E_P7   = 32'hFF03031F;
  localparam logic [31:0] E_N7   = 32'hFD03031F;
  localparam logic [31:0] E_Z    = 32'hFF030303;
  localparam logic [31:0] E_5    = 32'hFF030349;
  localparam logic [31:0] E_20   = 32'hFF032503;
  localparam logic [31:0] E_30   = 32'hFF030D03;
  localparam logic [31:0] E_N1   = 32'hFD03039F;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Starts and ends at a falling edge; checks latency, busy time, output stability and value.
  task automatic xfer(input logic [7:0] v, input logic [31:0] exp_seg, input string tag);
    int          lat;
    int          rl;
    bit          stable;
    logic [31:0] prev;
    for (int n = 0; n < 40 && !bus.in_ready; n++) @(negedge clk);
    check({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    prev         = bus.o_seg;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h5A;
    lat    = 0;
    rl     = bus.in_ready ? 0 : 1;
    stable = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = n;
        break;
      end
      if (!bus.in_ready) rl++;
      if (bus.o_seg !== prev) stable = 1'b0;
    end
    check({tag, "_latency"}, 32'(lat), 32'd9);
    check({tag, "_busy"}, 32'(rl), 32'd9);
    check({tag, "_stable"}, 32'(stable), 32'd1);
    check({tag, "_seg"}, bus.o_seg, exp_seg);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nd;
    logic [31:0] dv;
    n_cmp        = 0;
    n_bad        = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_seg", bus.o_seg, 32'hFFFFFFFF);
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);

    xfer(8'h80, E_N128, "n128");
    xfer(8'h07, E_P7, "p7");
    xfer(8'hF9, E_N7, "n7");
    xfer(8'h00, E_Z, "zero");
    xfer(8'h7F, E_127, "p127");
    xfer(8'h9C, E_N100, "n100");
    xfer(8'hFF, E_N1, "n1");

    // Continuous valid with fresh data every cycle: only 20 and 30 get taken.
    nd = 0;
    dv = '0;
    for (int c = 0; c <= 20; c++) begin
      if (bus.done) begin
        nd++;
        dv[c] = 1'b1;
      end
      if (c == 10) check("stream_seg20", bus.o_seg, E_20);
      if (c == 20) check("stream_seg30", bus.o_seg, E_30);
      if (c < 20) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 8'(20 + c);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("stream_done_count", 32'(nd), 32'd2);
    check("stream_done_c10", 32'(dv[10]), 32'd1);
    check("stream_done_c20", 32'(dv[20]), 32'd1);

    // Reset during the fourth conversion cycle of -128 after showing 5.
    xfer(8'h05, E_5, "five");
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h80;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_seg", bus.o_seg, 32'hFFFFFFFF);
    check("abort_ready", 32'(bus.in_ready), 32'd1);
    nd = 0;
    for (int n = 0; n < 15; n++) begin
      if (bus.done) nd++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(nd), 32'd0);
    check("abort_seg_hold", bus.o_seg, 32'hFFFFFFFF);
    xfer(8'h80, E_N128, "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
